// File: rtl/tone_seq.sv
// Memory-mapped tone sequencer: a FIFO of (half-period, duration) notes played as a square wave.
// Optional drained interrupt is built when TONE_SEQ_IRQ_EN is defined.
module tone_seq #(
   parameter int unsigned ADDRWIDTH = 8,
   parameter int unsigned FIFO_AW   = 4,
   parameter int unsigned TICK_DIV  = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr,
   input  logic [ADDRWIDTH-1:0] waddr,
   input  logic [31:0]          wdata,
   input  logic                 rd,
   input  logic [ADDRWIDTH-1:0] raddr,
   output logic [31:0]          rdata,
   output logic                 tone_pin,
   output logic                 irq
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {StIdle, StLoad, StPlay} state_e;

   logic [31:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] wptr, rptr;
   logic [FIFO_AW:0]   count;
   logic               run, overflow;
   state_e             state;
   logic [19:0]        hp, hcnt;
   logic [11:0]        dur;
   logic [TW-1:0]      tcnt;
   logic [31:0]        status;

   logic note_wr, ctrl_wr, stat_wr, empty, full, abort, flush, pop, push_ok;

   assign note_wr = wr && (waddr[3:2] == 2'd0);
   assign ctrl_wr = wr && (waddr[3:2] == 2'd1);
   assign stat_wr = wr && (waddr[3:2] == 2'd2);
   assign empty   = (count == '0);
   assign full    = (count == (FIFO_AW+1)'(DEPTH));
   assign flush   = ctrl_wr && wdata[1];
   assign abort   = ctrl_wr && (!wdata[0] || wdata[1]);
   // An abort in the same cycle wins over a pending pop so the FIFO keeps that entry.
   assign pop     = (state == StIdle) && run && !empty && !abort;
   assign push_ok = note_wr && !flush && (!full || pop);

   always_comb begin
      status              = '0;
      status[FIFO_AW:0]   = count;
      status[8]           = empty;
      status[9]           = full;
      status[10]          = (state != StIdle);
      status[11]          = overflow;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         run      <= 1'b0;
         overflow <= 1'b0;
         state    <= StIdle;
         hp       <= '0;
         hcnt     <= '0;
         dur      <= '0;
         tcnt     <= '0;
         tone_pin <= 1'b0;
         rdata    <= '0;
      end else begin
         if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
         end

         if (stat_wr) overflow <= 1'b0;
         else if (note_wr && !flush && full && !pop) overflow <= 1'b1;

         if (ctrl_wr) run <= wdata[0];

         if (abort) begin
            state    <= StIdle;
            tone_pin <= 1'b0;
         end else begin
            case (state)
               StIdle: begin
                  if (pop) begin
                     hp    <= mem[rptr][19:0];
                     dur   <= mem[rptr][31:20];
                     state <= StLoad;
                  end
               end
               StLoad: begin
                  hcnt     <= '0;
                  tcnt     <= '0;
                  tone_pin <= 1'b0;
                  state    <= (dur == '0) ? StIdle : StPlay;
               end
               StPlay: begin
                  // A rest (hp == 0) leaves the half-period counter and the pin untouched.
                  if (hp != '0) begin
                     if (hcnt == hp - 20'd1) begin
                        hcnt     <= '0;
                        tone_pin <= ~tone_pin;
                     end else begin
                        hcnt <= hcnt + 20'd1;
                     end
                  end
                  if (tcnt == TW'(TICK_DIV - 1)) begin
                     tcnt <= '0;
                     dur  <= dur - 12'd1;
                     if (dur == 12'd1) begin
                        tone_pin <= 1'b0;
                        state    <= StIdle;
                     end
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
               default: state <= StIdle;
            endcase
         end

         if (rd) begin
            case (raddr[3:2])
               2'd1:    rdata <= {31'd0, run};
               2'd2:    rdata <= status;
               default: rdata <= '0;
            endcase
         end
      end
   end

`ifdef TONE_SEQ_IRQ_EN
   logic drained, drained_q, irq_q;

   assign drained = run && empty && (state == StIdle);

   // Set only on entry into the drained condition, so an ack stays effective while still empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         drained_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         drained_q <= drained;
         if (note_wr || (ctrl_wr && (!wdata[0] || wdata[2]))) irq_q <= 1'b0;
         else if (drained && !drained_q) irq_q <= 1'b1;
      end
   end

   assign irq = irq_q;

   logic unused_bits;
   assign unused_bits = ^{waddr[ADDRWIDTH-1:4], waddr[1:0], raddr[ADDRWIDTH-1:4], raddr[1:0]};
`else
   assign irq = 1'b0;

   logic unused_bits;
   assign unused_bits = ^{waddr[ADDRWIDTH-1:4], waddr[1:0], raddr[ADDRWIDTH-1:4], raddr[1:0],
                          wdata[2]};
`endif

endmodule

// File: tb/tb_tone_seq.sv
// Directed bench for tone_seq with TICK_DIV=4: register table, then multi-cycle playback sequences.
module tb_tone_seq;

   logic        clk = 1'b0;
   logic        rst, wr, rd;
   logic [7:0]  waddr, raddr;
   logic [31:0] wdata, rdata;
   logic        tone_pin, irq;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef TONE_SEQ_IRQ_EN
   localparam logic IRQ_EN = 1'b1;
`else
   localparam logic IRQ_EN = 1'b0;
`endif

   localparam logic [7:0] A_NOTE = 8'h00;
   localparam logic [7:0] A_CTRL = 8'h04;
   localparam logic [7:0] A_STAT = 8'h08;
   localparam logic [7:0] A_RSV  = 8'h0C;

   always #5 clk = ~clk;

   tone_seq #(
      .ADDRWIDTH(8),
      .FIFO_AW  (4),
      .TICK_DIV (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr),
      .waddr   (waddr),
      .wdata   (wdata),
      .rd      (rd),
      .raddr   (raddr),
      .rdata   (rdata),
      .tone_pin(tone_pin),
      .irq     (irq)
   );

   typedef struct {
      logic        is_wr;
      logic [7:0]  addr;
      logic [31:0] data;   // write data, or expected read data
      string       name;
   } vec_t;

   vec_t vecs[12];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      wr    = 1'b1;
      waddr = a;
      wdata = d;
      tick();
      wr    = 1'b0;
   endtask

   task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
      rd    = 1'b1;
      raddr = a;
      tick();
      rd    = 1'b0;
      d     = rdata;
   endtask

   task automatic wait_irq(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (irq) break;
         tick();
      end
   endtask

   function automatic logic [31:0] note(input int unsigned d, input int unsigned h);
      return (32'(d) << 20) | 32'(h);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      logic [31:0] st_exp[10];
      logic        pin_exp;

      rst = 1'b1; wr = 1'b0; rd = 1'b0;
      waddr = '0; raddr = '0; wdata = '0;
      repeat (3) tick();
      check("reset rdata", rdata, 32'h0);
      check("reset pin", 32'(tone_pin), 32'h0);
      check("reset irq", 32'(irq), 32'h0);
      rst = 1'b0;

      vecs[0]  = '{1'b0, A_STAT, 32'h100,      "reset status"};
      vecs[1]  = '{1'b0, A_CTRL, 32'h0,        "reset ctrl"};
      vecs[2]  = '{1'b1, A_CTRL, 32'h1,        ""};
      vecs[3]  = '{1'b0, A_CTRL, 32'h1,        "run set"};
      vecs[4]  = '{1'b0, A_NOTE, 32'h0,        "note reads 0"};
      vecs[5]  = '{1'b0, A_RSV,  32'h0,        "reserved reads 0"};
      vecs[6]  = '{1'b1, A_CTRL, 32'h3,        ""};
      vecs[7]  = '{1'b0, A_CTRL, 32'h1,        "flush self-clears"};
      vecs[8]  = '{1'b1, A_CTRL, 32'h0,        ""};
      vecs[9]  = '{1'b1, A_RSV,  32'hffffffff, ""};
      vecs[10] = '{1'b0, A_CTRL, 32'h0,        "run cleared"};
      vecs[11] = '{1'b0, 8'h0B,  32'h100,      "status via addr[1:0]=3"};

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].is_wr) begin
            bus_wr(vecs[i].addr, vecs[i].data);
         end else begin
            bus_rd(vecs[i].addr, r);
            check(vecs[i].name, r, vecs[i].data);
         end
      end

      // rdata holds when rd is low
      raddr = A_CTRL;
      tick();
      check("rdata hold", rdata, 32'h100);

      // Single note dur=3 hp=2: toggles at run+4,+6,+8,+10,+12, forced low at +14
      bus_wr(A_NOTE, note(3, 2));
      bus_wr(A_CTRL, 32'h1);
      for (int k = 1; k <= 16; k++) begin
         tick();
         pin_exp = (k >= 4) && (k <= 13) && (((k / 2) % 2) == 0);
         check($sformatf("t2 pin after edge %0d", k), 32'(tone_pin), 32'(pin_exp));
      end
      bus_rd(A_STAT, r);
      check("t2 status idle empty", r, 32'h100);
      check("t2 irq after drain", 32'(irq), 32'(IRQ_EN));

      // Overflow with 17 pushes while stopped
      bus_wr(A_CTRL, 32'h0);
      for (int i = 0; i < 17; i++) bus_wr(A_NOTE, note(1, i));
      bus_rd(A_STAT, r);
      check("t3 full+overflow", r, 32'hA10);
      bus_wr(A_STAT, 32'h0);
      bus_rd(A_STAT, r);
      check("t3 overflow cleared", r, 32'h210);
      bus_wr(A_CTRL, 32'h2);
      bus_rd(A_STAT, r);
      check("t3 flushed", r, 32'h100);
      bus_rd(A_CTRL, r);
      check("t3 run kept 0", r, 32'h0);

      // dur=0 entry discarded, then a 4-cycle rest; status sampled every cycle
      bus_wr(A_NOTE, note(0, 7));
      bus_wr(A_NOTE, note(1, 0));
      bus_wr(A_CTRL, 32'h1);
      st_exp = '{32'h002, 32'h401, 32'h001, 32'h500, 32'h500,
                 32'h500, 32'h500, 32'h500, 32'h100, 32'h100};
      for (int k = 0; k < 10; k++) begin
         rd    = 1'b1;
         raddr = A_STAT;
         tick();
         check($sformatf("t4 status %0d", k), rdata, st_exp[k]);
         check($sformatf("t4 rest pin %0d", k), 32'(tone_pin), 32'h0);
      end
      rd = 1'b0;

      // Abort with run=0 keeps the queued note; flush during play empties and keeps run
      bus_wr(A_CTRL, 32'h0);
      bus_wr(A_NOTE, note(100, 5));
      bus_wr(A_NOTE, note(100, 5));
      bus_wr(A_CTRL, 32'h1);
      repeat (10) tick();
      check("t5 pin high mid-note", 32'(tone_pin), 32'h1);
      bus_wr(A_CTRL, 32'h0);
      check("t5 pin low after stop", 32'(tone_pin), 32'h0);
      bus_rd(A_STAT, r);
      check("t5 stop keeps fifo", r, 32'h001);
      bus_wr(A_CTRL, 32'h1);
      repeat (7) tick();
      check("t5 second note toggles", 32'(tone_pin), 32'h1);
      bus_wr(A_CTRL, 32'h3);
      check("t5 pin low after flush", 32'(tone_pin), 32'h0);
      bus_rd(A_STAT, r);
      check("t5 status after flush", r, 32'h100);
      bus_rd(A_CTRL, r);
      check("t5 run kept after flush", r, 32'h1);

      // Drained interrupt: set, ack, stays low, re-armed by a new note
      bus_wr(A_CTRL, 32'h0);
      check("t6 irq cleared by stop", 32'(irq), 32'h0);
      bus_wr(A_NOTE, note(1, 1));
      bus_wr(A_CTRL, 32'h1);
      check("t6 irq low while queued", 32'(irq), 32'h0);
      wait_irq(30);
      check("t6 irq after drain", 32'(irq), 32'(IRQ_EN));
      bus_wr(A_CTRL, 32'h5);
      check("t6 irq acked", 32'(irq), 32'h0);
      repeat (5) tick();
      check("t6 irq stays low", 32'(irq), 32'h0);
      bus_wr(A_NOTE, note(1, 1));
      check("t6 irq low after push", 32'(irq), 32'h0);
      wait_irq(30);
      check("t6 irq after second drain", 32'(irq), 32'(IRQ_EN));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
